// File: rtl/pix_pkg.sv
// Shared constants and helpers for the byte-stream to pixel packing path.
package pix_pkg;

  localparam int unsigned PIX_CHANNELS = 3;
  localparam int unsigned PIX_DATA_W   = 8;

  localparam int unsigned SYS_CLK_HZ      = 100_000_000;
  localparam int unsigned UART_TIMEOUT_US = 2000;
  localparam int unsigned UART_TIMEOUT_CYC = (SYS_CLK_HZ / 1_000_000) * UART_TIMEOUT_US;

  typedef enum logic {
    StIdle,
    StCollect
  } pack_state_e;

  // Width of a counter indexing n items; never below one bit.
  function automatic int unsigned clog2_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/idle_timer.sv
// Silence timer: counts while enabled, restarts on clear, pulses expire on the last count.
module idle_timer #(
  parameter int unsigned TIMEOUT_CYC = 200000,
  parameter int unsigned CNT_W       = 18
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned Last    = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
  localparam logic        Enabled = (TIMEOUT_CYC != 0);

  logic [CNT_W-1:0] timer_q, timer_d;
  logic             at_last;

  assign at_last  = (timer_q == CNT_W'(Last));
  // A clear in the expiry cycle means fresh data arrived, so it suppresses the pulse.
  assign expire_o = Enabled && enable_i && !clear_i && at_last;

  always_comb begin
    timer_d = timer_q;
    if (clear_i || expire_o) begin
      timer_d = '0;
    end else if (enable_i && !at_last) begin
      timer_d = timer_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/byte_to_pixel_packer.sv
// Packs CHANNELS consecutive strobed words into one pixel behind a one-entry valid/ready buffer.
module byte_to_pixel_packer
  import pix_pkg::*;
#(
  parameter int unsigned CHANNELS    = PIX_CHANNELS,
  parameter int unsigned DATA_W      = PIX_DATA_W,
  parameter int unsigned TIMEOUT_CYC = UART_TIMEOUT_CYC,
  parameter int unsigned CNT_W       = 18
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       data_in_valid,
  input  logic [DATA_W-1:0]          data_in,
  output logic [CHANNELS*DATA_W-1:0] pix_data,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic                       busy,
  output logic                       timeout_err,
  output logic                       overflow
);

  localparam int unsigned ChW  = clog2_w(CHANNELS);
  localparam int unsigned PixW = CHANNELS * DATA_W;

  pack_state_e     state_q, state_d;
  logic [ChW-1:0]  ch_cnt_q, ch_cnt_d;
  logic [PixW-1:0] acc_q, acc_d;
  logic [PixW-1:0] pix_data_q, pix_data_d;
  logic            pix_valid_q, pix_valid_d;
  logic            timeout_err_q, timeout_err_d;
  logic            overflow_q, overflow_d;
  logic            last_word, drain, expire;

  assign last_word = (ch_cnt_q == ChW'(CHANNELS - 1));
  assign drain     = pix_valid_q && pix_ready;

  idle_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CNT_W      (CNT_W)
  ) u_idle_timer (
    .clk_i   (sys_clk),
    .rst_ni  (sys_rst_n),
    .clear_i (data_in_valid),
    .enable_i(state_q == StCollect),
    .expire_o(expire)
  );

  always_comb begin
    state_d       = state_q;
    ch_cnt_d      = ch_cnt_q;
    acc_d         = acc_q;
    pix_data_d    = pix_data_q;
    pix_valid_d   = pix_valid_q;
    timeout_err_d = 1'b0;
    overflow_d    = 1'b0;

    if (drain) begin
      pix_valid_d = 1'b0;
    end

    if (data_in_valid) begin
      // First word lands in the MSB field.
      acc_d[PixW - 1 - int'(ch_cnt_q) * DATA_W -: DATA_W] = data_in;
      if (last_word) begin
        ch_cnt_d = '0;
        state_d  = StIdle;
        if (!pix_valid_q || drain) begin
          pix_data_d  = acc_d;
          pix_valid_d = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end else begin
        ch_cnt_d = ch_cnt_q + ChW'(1);
        state_d  = StCollect;
      end
    end else if (expire) begin
      ch_cnt_d      = '0;
      state_d       = StIdle;
      timeout_err_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= StIdle;
      ch_cnt_q      <= '0;
      acc_q         <= '0;
      pix_data_q    <= '0;
      pix_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_cnt_q      <= ch_cnt_d;
      acc_q         <= acc_d;
      pix_data_q    <= pix_data_d;
      pix_valid_q   <= pix_valid_d;
      timeout_err_q <= timeout_err_d;
      overflow_q    <= overflow_d;
    end
  end

  assign pix_data    = pix_data_q;
  assign pix_valid   = pix_valid_q;
  assign busy        = (ch_cnt_q != '0);
  assign timeout_err = timeout_err_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_byte_to_pixel_packer.sv
// Directed bench: default packer, a short-timeout packer and a four-channel packer on one stream.
module tb_byte_to_pixel_packer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] din = 8'h00;
  logic       ready = 1'b1;

  logic [23:0] d_pix;
  logic        d_valid, d_busy, d_to, d_ovf;
  logic [23:0] t_pix;
  logic        t_valid, t_busy, t_to, t_ovf;
  logic [31:0] q_pix;
  logic        q_valid, q_busy, q_to, q_ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int d_ovf_cnt = 0;
  int t_to_cnt  = 0;
  int q_to_cnt  = 0;

  always #5 clk = ~clk;

  byte_to_pixel_packer dut_def (
    .sys_clk(clk), .sys_rst_n(rst_n), .data_in_valid(valid), .data_in(din),
    .pix_data(d_pix), .pix_valid(d_valid), .pix_ready(ready), .busy(d_busy),
    .timeout_err(d_to), .overflow(d_ovf)
  );

  byte_to_pixel_packer #(.CHANNELS(3), .DATA_W(8), .TIMEOUT_CYC(100), .CNT_W(7)) dut_to (
    .sys_clk(clk), .sys_rst_n(rst_n), .data_in_valid(valid), .data_in(din),
    .pix_data(t_pix), .pix_valid(t_valid), .pix_ready(ready), .busy(t_busy),
    .timeout_err(t_to), .overflow(t_ovf)
  );

  byte_to_pixel_packer #(.CHANNELS(4), .DATA_W(8), .TIMEOUT_CYC(4), .CNT_W(3)) dut4 (
    .sys_clk(clk), .sys_rst_n(rst_n), .data_in_valid(valid), .data_in(din),
    .pix_data(q_pix), .pix_valid(q_valid), .pix_ready(ready), .busy(q_busy),
    .timeout_err(q_to), .overflow(q_ovf)
  );

  always @(posedge clk) begin
    if (d_ovf) d_ovf_cnt++;
    if (t_to)  t_to_cnt++;
    if (q_to)  q_to_cnt++;
  end

  task automatic drive(input logic [7:0] d);
    @(negedge clk);
    din   = d;
    valid = 1'b1;
  endtask

  task automatic stop_strobe();
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ready = 1'b1;
    #1;
    n_checks++;
    if ({d_valid, d_busy, d_to, d_ovf} !== 4'b0000) begin
      $display("FAIL reset_flags: got %b expected 0000", {d_valid, d_busy, d_to, d_ovf});
      n_fail++;
    end
    n_checks++;
    if (d_pix !== 24'h0) begin
      $display("FAIL reset_pix: got %h expected 000000", d_pix);
      n_fail++;
    end
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    apply_reset();
    ready = 1'b1;
    drive(8'h11); stop_strobe();
    n_checks++;
    if (d_busy !== 1'b1) begin
      $display("FAIL basic_busy_set: got %b expected 1", d_busy);
      n_fail++;
    end
    idle(3998);
    drive(8'h22); stop_strobe();
    n_checks++;
    if (d_valid !== 1'b0) begin
      $display("FAIL basic_early_valid: got %b expected 0", d_valid);
      n_fail++;
    end
    idle(3998);
    drive(8'h33); stop_strobe();
    n_checks++;
    if (d_valid !== 1'b1 || d_pix !== 24'h112233) begin
      $display("FAIL basic_pixel: got valid=%b pix=%h expected valid=1 pix=112233", d_valid, d_pix);
      n_fail++;
    end
    n_checks++;
    if (d_busy !== 1'b0) begin
      $display("FAIL basic_busy_clear: got %b expected 0", d_busy);
      n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (d_valid !== 1'b0) begin
      $display("FAIL basic_one_cycle: got valid=%b expected 0", d_valid);
      n_fail++;
    end
  endtask

  task automatic test_timeout();
    int lat;
    int s;
    apply_reset();
    ready = 1'b1;
    s = t_to_cnt;
    lat = -1;
    drive(8'h01); drive(8'h02); stop_strobe();
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (t_to && lat < 0) lat = i;
    end
    n_checks++;
    if (lat != 100) begin
      $display("FAIL timeout_latency: got %0d cycles expected 100", lat);
      n_fail++;
    end
    n_checks++;
    if (t_to_cnt - s != 1) begin
      $display("FAIL timeout_pulses: got %0d expected 1", t_to_cnt - s);
      n_fail++;
    end
    n_checks++;
    if (t_busy !== 1'b0 || t_valid !== 1'b0) begin
      $display("FAIL timeout_state: got busy=%b valid=%b expected 0 0", t_busy, t_valid);
      n_fail++;
    end
    drive(8'hAA); drive(8'hBB); drive(8'hCC); stop_strobe();
    n_checks++;
    if (t_valid !== 1'b1 || t_pix !== 24'hAABBCC) begin
      $display("FAIL timeout_resync: got valid=%b pix=%h expected 1 AABBCC", t_valid, t_pix);
      n_fail++;
    end
  endtask

  task automatic test_overflow();
    int s;
    apply_reset();
    ready = 1'b0;
    s = d_ovf_cnt;
    for (int b = 8'h10; b <= 8'h15; b++) drive(8'(b));
    stop_strobe();
    n_checks++;
    if (d_ovf !== 1'b1 || d_pix !== 24'h101112 || d_valid !== 1'b1) begin
      $display("FAIL ovf_pulse: got ovf=%b pix=%h valid=%b expected 1 101112 1",
               d_ovf, d_pix, d_valid);
      n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (d_ovf !== 1'b0 || d_pix !== 24'h101112) begin
      $display("FAIL ovf_hold: got ovf=%b pix=%h expected 0 101112", d_ovf, d_pix);
      n_fail++;
    end
    ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (d_valid !== 1'b0) begin
      $display("FAIL ovf_accept: got valid=%b expected 0", d_valid);
      n_fail++;
    end
    n_checks++;
    if (d_ovf_cnt - s != 1) begin
      $display("FAIL ovf_count: got %0d expected 1", d_ovf_cnt - s);
      n_fail++;
    end
  endtask

  task automatic test_drain_reload();
    int s;
    apply_reset();
    ready = 1'b0;
    s = d_ovf_cnt;
    drive(8'h12); drive(8'h34); drive(8'h56); stop_strobe();
    n_checks++;
    if (d_valid !== 1'b1 || d_pix !== 24'h123456) begin
      $display("FAIL reload_held: got valid=%b pix=%h expected 1 123456", d_valid, d_pix);
      n_fail++;
    end
    drive(8'h9A); drive(8'hBC); drive(8'hDE);
    ready = 1'b1;
    stop_strobe();
    ready = 1'b0;
    n_checks++;
    if (d_valid !== 1'b1 || d_pix !== 24'h9ABCDE || d_ovf !== 1'b0) begin
      $display("FAIL reload_pixel: got valid=%b pix=%h ovf=%b expected 1 9ABCDE 0",
               d_valid, d_pix, d_ovf);
      n_fail++;
    end
    n_checks++;
    if (d_ovf_cnt != s) begin
      $display("FAIL reload_no_ovf: got %0d pulses expected 0", d_ovf_cnt - s);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    ready = 1'b0;
    drive(8'h21); drive(8'h22); drive(8'h23); drive(8'h24); drive(8'h25);
    @(negedge clk);
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({d_valid, d_busy, d_to, d_ovf} !== 4'b0000 || d_pix !== 24'h0) begin
      $display("FAIL midreset_outputs: got valid=%b busy=%b to=%b ovf=%b pix=%h expected all 0",
               d_valid, d_busy, d_to, d_ovf, d_pix);
      n_fail++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    drive(8'h01); drive(8'h02); drive(8'h03); stop_strobe();
    n_checks++;
    if (d_valid !== 1'b1 || d_pix !== 24'h010203) begin
      $display("FAIL midreset_pixel: got valid=%b pix=%h expected 1 010203", d_valid, d_pix);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    int s;
    apply_reset();
    ready = 1'b1;
    drive(8'hDE); drive(8'hAD); drive(8'hBE); drive(8'hEF); stop_strobe();
    n_checks++;
    if (q_valid !== 1'b1 || q_pix !== 32'hDEADBEEF) begin
      $display("FAIL b2b_pixel: got valid=%b pix=%h expected 1 DEADBEEF", q_valid, q_pix);
      n_fail++;
    end
    s = q_to_cnt;
    // Each following strobe lands exactly in the expiry cycle of the 4-cycle timer.
    drive(8'hC0); stop_strobe(); idle(2);
    drive(8'hFF); stop_strobe(); idle(2);
    drive(8'hEE); stop_strobe(); idle(2);
    drive(8'h11); stop_strobe();
    n_checks++;
    if (q_valid !== 1'b1 || q_pix !== 32'hC0FFEE11) begin
      $display("FAIL expiry_continue: got valid=%b pix=%h expected 1 C0FFEE11", q_valid, q_pix);
      n_fail++;
    end
    n_checks++;
    if (q_to_cnt != s) begin
      $display("FAIL expiry_no_timeout: got %0d pulses expected 0", q_to_cnt - s);
      n_fail++;
    end
    drive(8'h55); stop_strobe(); idle(3);
    @(negedge clk);
    n_checks++;
    if (q_to !== 1'b1 || q_busy !== 1'b0 || q_pix !== 32'hC0FFEE11) begin
      $display("FAIL expiry_timeout: got to=%b busy=%b pix=%h expected 1 0 C0FFEE11",
               q_to, q_busy, q_pix);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_overflow();
    test_drain_reload();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_to_pixel_packer.md
Name: byte_to_pixel_packer

Overview:
Parametrised successor to the byte-to-RGB assembler that sits between uart_rx and the pixel-processing stage. It collects CHANNELS consecutive DATA_W-bit words from a pulse-valid byte stream into one packed pixel, and presents that pixel on a valid/ready handshake. It adds an inter-byte timeout that resynchronises on a dropped byte, backpressure with a one-entry output buffer, and overflow reporting.

Parameters:
CHANNELS, 3, words per pixel (legal range 2..8)
DATA_W, 8, width of each incoming word/channel
TIMEOUT_CYC, 200000, sys_clk cycles of silence after which a partial pixel is discarded; 0 disables the timeout
CNT_W, 18, width of the timeout counter; must hold TIMEOUT_CYC-1

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst_n  in  1  asynchronous active-low reset
data_in_valid  in  1  single-cycle strobe; data_in is valid in this cycle; back-to-back strobes are legal
data_in  in  DATA_W  incoming word
pix_data  out  CHANNELS*DATA_W  packed pixel; the first word received occupies the MSB field
pix_valid  out  1  pixel available; held until accepted
pix_ready  in  1  downstream accepts the pixel when pix_valid && pix_ready
busy  out  1  a partial pixel is held (ch_cnt != 0)
timeout_err  out  1  one-cycle pulse when a partial pixel is discarded by timeout
overflow  out  1  one-cycle pulse when a completed pixel is dropped because the output is full

Behaviour:
- Reset (async, sys_rst_n=0): all outputs 0, ch_cnt=0, accumulator=0, timer=0. Reset mid-collection discards the partial pixel and any held pixel.
- FSM has two states. IDLE (ch_cnt=0) -> COLLECT on a strobe. COLLECT -> IDLE on pixel completion or timeout.
- Each strobe writes data_in into field ch_cnt. Field k occupies bits [(CHANNELS-k)*DATA_W-1 -: DATA_W]. ch_cnt then increments.
- Completion: a strobe arriving with ch_cnt==CHANNELS-1 completes the pixel and ch_cnt returns to 0.
  - If the output register is empty, or is being drained this same cycle (pix_valid && pix_ready), the pixel is loaded. pix_valid=1 from the next cycle, so latency is 1 cycle from the final strobe.
  - Otherwise the new pixel is dropped, the held pixel is kept unchanged, and overflow pulses for 1 cycle.
- Output register: pix_data is stable while pix_valid=1 and !pix_ready. pix_valid clears the cycle after acceptance unless it is reloaded in the same cycle.
- Timeout timer:
  - Cleared on every strobe; counts only while busy=1.
  - When it reaches TIMEOUT_CYC-1 with no strobe that cycle: ch_cnt=0, timer=0, timeout_err pulses next cycle.
  - If a strobe coincides with expiry, the strobe wins: it counts as a continuation and the timer clears.
  - No timeout when TIMEOUT_CYC=0.
- A timeout never affects the output register.
- Arithmetic: ch_cnt width is $clog2(CHANNELS), and it never exceeds CHANNELS-1. The timer saturates at the expiry value and does not wrap.

Decomposition:
- Shared package pix_pkg holds the default constants:
  - PIX_CHANNELS=3
  - PIX_DATA_W=8
  - UART_TIMEOUT_CYC (derived from clock/baud: 200000 at 100 MHz)
  - a localparam function for clog2 widths.
- One natural sub-module: idle_timer. Inputs: clear, enable. Output: expire pulse. Parameters: TIMEOUT_CYC, CNT_W. The packer instantiates it; everything else stays in the top module.

Test Plan:
1. Defaults, pix_ready=1. Strobes 0x11, 0x22, 0x33, 40000 ns apart -> pix_data=0x112233 and pix_valid high for exactly 1 cycle, starting 1 cycle after the 0x33 strobe; busy toggles 1 then 0.
2. TIMEOUT_CYC=100. Strobes 0x01, 0x02, then idle -> timeout_err pulses once, about 100 cycles after 0x02, with busy then 0 and no pix_valid. Then strobes 0xAA, 0xBB, 0xCC -> pix_data=0xAABBCC.
3. pix_ready=0. Send 6 bytes 0x10..0x15 -> the first pixel 0x101112 is held, overflow pulses once at the 0x15 strobe, pix_data stays 0x101112. Raise pix_ready -> accepted, pix_valid drops.
4. pix_ready=0, pixel 0x123456 held. Send 0x9A, 0xBC, then raise pix_ready in the same cycle as the 0xDE strobe -> no overflow, 0x123456 accepted, next cycle pix_data=0x9ABCDE and pix_valid=1.
5. Reset asserted for 1 cycle after 2 of 3 bytes -> all outputs 0. The next 3 bytes 0x01, 0x02, 0x03 yield 0x010203 (no stale field).
6. CHANNELS=4, DATA_W=8, back-to-back strobes 0xDE, 0xAD, 0xBE, 0xEF on consecutive cycles -> pix_data=0xDEADBEEF, and the strobe coinciding with the timer expiry cycle is accepted as a continuation.
